// File: rtl/dmem_sync.sv
// -----------------------------------------------------------------------------
// dmem_sync
//    Single-clock data memory with one read port and one byte-maskable write
//    port. After reset the array can be swept to zero (CLEAR_ON_RESET=1); the
//    sweep takes exactly DEPTH cycles and all requests are dropped while it runs.
//
// Ports
//    clk           rising-edge clock
//    reset         synchronous active-high reset
//    readEnable    read request
//    readAddress   read word address (ADDR_W bits)
//    readData      registered read data, valid one cycle after the request
//    readValid     readData carries the answer to last cycle's read
//    writeEnable   write request
//    writeAddress  write word address (ADDR_W bits)
//    writeData     write data (DATA_W bits)
//    byteEnable    per-byte write mask, bit i covers bits [8i+7:8i]
//    busy          clear sweep in progress, requests ignored
//    addrError     one-cycle pulse after an out-of-range enabled request
// -----------------------------------------------------------------------------
module dmem_sync #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 9,
   parameter int DEPTH          = 512,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  readEnable,
   input  logic [ADDR_W-1:0]     readAddress,
   output logic [DATA_W-1:0]     readData,
   output logic                  readValid,
   input  logic                  writeEnable,
   input  logic [ADDR_W-1:0]     writeAddress,
   input  logic [DATA_W-1:0]     writeData,
   input  logic [DATA_W/8-1:0]   byteEnable,
   output logic                  busy,
   output logic                  addrError
);

   localparam int NB = DATA_W / 8;

   // Depth and last sweep index held one bit wider than the address so that
   // DEPTH = 2**ADDR_W is representable and the sweep ends without wrapping.
   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Replace the bytes of old_w selected by be with the bytes of new_w.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [NB-1:0]     be
   );
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];

   state_t            state_q,      state_d;
   logic [ADDR_W:0]   clear_idx_q,  clear_idx_d;
   logic [DATA_W-1:0] read_data_q,  read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              addr_error_q, addr_error_d;

   logic              rd_in_range_s;
   logic              wr_in_range_s;
   logic              wr_hit_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic [NB-1:0]     mem_be_s;

   // Address range decode for both ports.
   always_comb begin
      rd_in_range_s = ({1'b0, readAddress}  < DEPTH_W);
      wr_in_range_s = ({1'b0, writeAddress} < DEPTH_W);
      wr_hit_s      = writeEnable && wr_in_range_s && (writeAddress == readAddress);
   end

   // Controller next state, array write port selection and read result.
   always_comb begin
      state_d      = state_q;
      clear_idx_d  = clear_idx_q;
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      addr_error_d = 1'b0;
      mem_we_s     = 1'b0;
      mem_addr_s   = {ADDR_W{1'b0}};
      mem_wdata_s  = {DATA_W{1'b0}};
      mem_be_s     = {NB{1'b0}};

      case (state_q)
         ST_CLEAR: begin
            // One zero word per cycle; requests are dropped entirely.
            mem_we_s    = 1'b1;
            mem_addr_s  = clear_idx_q[ADDR_W-1:0];
            mem_be_s    = {NB{1'b1}};
            mem_wdata_s = {DATA_W{1'b0}};
            clear_idx_d = clear_idx_q + (ADDR_W+1)'(1);
            if (clear_idx_q == LAST_IDX) begin
               state_d = ST_READY;
            end else begin
               state_d = ST_CLEAR;
            end
         end

         ST_READY: begin
            state_d = ST_READY;
            if (writeEnable && wr_in_range_s) begin
               mem_we_s    = 1'b1;
               mem_addr_s  = writeAddress;
               mem_wdata_s = writeData;
               mem_be_s    = byteEnable;
            end else begin
               mem_we_s    = 1'b0;
            end

            if (readEnable) begin
               read_valid_d = 1'b1;
               if (!rd_in_range_s) begin
                  read_data_d = {DATA_W{1'b0}};
               end else if (wr_hit_s) begin
                  // Write-first: the reader sees the word as it will be after this edge.
                  read_data_d = merge_bytes(mem_q[readAddress], writeData, byteEnable);
               end else begin
                  read_data_d = mem_q[readAddress];
               end
            end else begin
               read_data_d = read_data_q;
            end

            // A read error and a write error in the same cycle share one pulse.
            addr_error_d = (readEnable && !rd_in_range_s) ||
                           (writeEnable && !wr_in_range_s);
         end

         default: begin
            state_d     = ST_CLEAR;
            clear_idx_d = {(ADDR_W+1){1'b0}};
         end
      endcase
   end

   // Controller and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clear_idx_q  <= {(ADDR_W+1){1'b0}};
         read_data_q  <= {DATA_W{1'b0}};
         read_valid_q <= 1'b0;
         addr_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clear_idx_q  <= clear_idx_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         addr_error_q <= addr_error_d;
      end
   end

   // Storage array: byte-masked write, no reset so contents survive reset
   // when the sweep is disabled. Writes in the reset cycle are discarded.
   always_ff @(posedge clk) begin
      if (!reset && mem_we_s) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be_s[i]) begin
               mem_q[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
            end
         end
      end
   end

   assign readData  = read_data_q;
   assign readValid = read_valid_q;
   assign addrError = addr_error_q;
   assign busy      = (state_q == ST_CLEAR);

endmodule
